// File: rtl/nn_traffic_unit.sv
// Nearest-neighbour traffic generator and ejection checker for one 3D-torus node.
// Build option: define CHECK_PAYLOAD_EN to also check payload sequence numbers on ejection.
module nn_traffic_unit #(
  parameter int CUR_X     = 0,
  parameter int CUR_Y     = 0,
  parameter int CUR_Z     = 0,
  parameter int XSIZE     = 4,
  parameter int YSIZE     = 4,
  parameter int ZSIZE     = 4,
  parameter int COORD_W   = 3,
  parameter int NUM_PORTS = 6,
  parameter int FLIT_W    = 128,
  parameter int PKT_FLITS = 16,
  parameter int PKT_NUM   = 10,
  parameter int INTERVAL  = 30
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [NUM_PORTS*FLIT_W-1:0] inject_flit,
  output logic [NUM_PORTS-1:0]        inject_valid,
  input  logic [NUM_PORTS-1:0]        inject_avail,
  input  logic [NUM_PORTS*FLIT_W-1:0] eject_flit,
  input  logic [NUM_PORTS-1:0]        eject_valid,
  output logic [NUM_PORTS*16-1:0]     sent_pkts,
  output logic [NUM_PORTS*16-1:0]     rcvd_pkts,
  output logic [NUM_PORTS-1:0]        err,
  output logic                        done
);

  // Handshake: an inject flit transfers on a cycle with inject_valid && inject_avail; while
  // valid is high and avail low the flit is held unchanged. Every eject_valid cycle is consumed.

  localparam int PAY_W   = FLIT_W - 3 - 3*COORD_W - 4;
  localparam int DZ_LSB  = FLIT_W - 3 - COORD_W;
  localparam int DY_LSB  = DZ_LSB - COORD_W;
  localparam int DX_LSB  = DY_LSB - COORD_W;
  localparam int TIMER_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef enum logic {G_IDLE, G_SEND} gen_state_t;
  typedef enum logic {C_WAIT_HEAD, C_IN_PKT} chk_state_t;

  function automatic logic [COORD_W-1:0] step(input int cur, input int size, input int delta);
    return COORD_W'((cur + size + delta) % size);
  endfunction

  logic                running;
  logic [TIMER_W-1:0]  timer;
  logic                tick;
  logic                run_start;
  logic [NUM_PORTS-1:0] port_done;

  assign run_start = start && !running;
  assign tick      = running && (timer == TIMER_W'(INTERVAL - 1));
  assign done      = &port_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      timer   <= '0;
    end else if (run_start) begin
      running <= 1'b1;
      timer   <= '0;
    end else if (running) begin
      if (done) running <= 1'b0;
      timer <= tick ? '0 : timer + 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam logic [COORD_W-1:0] DX = (p == 0) ? step(CUR_X, XSIZE, 1) :
                                        (p == 3) ? step(CUR_X, XSIZE, -1) : COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] DY = (p == 1) ? step(CUR_Y, YSIZE, 1) :
                                        (p == 4) ? step(CUR_Y, YSIZE, -1) : COORD_W'(CUR_Y);
    localparam logic [COORD_W-1:0] DZ = (p == 2) ? step(CUR_Z, ZSIZE, 1) :
                                        (p == 5) ? step(CUR_Z, ZSIZE, -1) : COORD_W'(CUR_Z);

    // ---------------- injection generator ----------------
    gen_state_t  g_state, g_state_n;
    logic        g_pending, g_pending_n;
    logic [15:0] g_idx, g_idx_n;
    logic [15:0] g_sent, g_sent_n;
    logic [1:0]  g_type;
    logic        accept, is_tail, may_issue;

    assign is_tail = (g_idx == 16'(PKT_FLITS - 1));
    assign accept  = (g_state == G_SEND) && inject_avail[p];
    // A packet in flight counts against PKT_NUM so a late opportunity cannot overshoot.
    assign may_issue = tick && (({1'b0, g_sent} + 17'(g_state == G_SEND)) < 17'(PKT_NUM));
    assign g_type = (g_idx == 16'd0) ? T_HEAD : (is_tail ? T_TAIL : T_BODY);

    always_comb begin
      g_state_n   = g_state;
      g_pending_n = g_pending | may_issue;
      g_idx_n     = g_idx;
      g_sent_n    = g_sent;
      case (g_state)
        G_IDLE: begin
          if (g_pending || may_issue) begin
            g_state_n   = G_SEND;
            g_pending_n = 1'b0;
            g_idx_n     = '0;
          end
        end
        G_SEND: begin
          if (accept) begin
            if (is_tail) begin
              if (g_sent != 16'hFFFF) g_sent_n = g_sent + 16'd1;
              g_idx_n = '0;
              if (g_pending || may_issue) g_pending_n = 1'b0;
              else                        g_state_n   = G_IDLE;
            end else begin
              g_idx_n = g_idx + 16'd1;
            end
          end
        end
        default: g_state_n = G_IDLE;
      endcase
      if (run_start) begin
        g_state_n   = G_IDLE;
        g_pending_n = 1'b0;
        g_idx_n     = '0;
        g_sent_n    = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        g_state   <= G_IDLE;
        g_pending <= 1'b0;
        g_idx     <= '0;
        g_sent    <= '0;
      end else begin
        g_state   <= g_state_n;
        g_pending <= g_pending_n;
        g_idx     <= g_idx_n;
        g_sent    <= g_sent_n;
      end
    end

    // The sequence number of the packet in flight equals the count of packets already sent.
    assign inject_valid[p] = (g_state == G_SEND);
    assign inject_flit[p*FLIT_W +: FLIT_W] = (g_state == G_SEND) ?
        {g_type, 1'b1, DZ, DY, DX, 4'(p), PAY_W'(g_sent)} : '0;
    assign sent_pkts[p*16 +: 16] = g_sent;

    // ---------------- ejection checker ----------------
    chk_state_t  c_state, c_state_n;
    logic [15:0] c_cnt, c_cnt_n, cnt_inc;
    logic [15:0] c_rcvd, c_rcvd_n;
    logic        c_err, c_err_n;
    logic [FLIT_W-1:0] ef;
    logic [1:0]  e_type;
    logic        dest_ok;
    logic        unused_bits;

    assign ef          = eject_flit[p*FLIT_W +: FLIT_W];
    assign e_type      = ef[FLIT_W-1 -: 2];
    assign cnt_inc     = c_cnt + 16'd1;
    assign unused_bits = ^ef;
    assign dest_ok     = (ef[DZ_LSB +: COORD_W] == COORD_W'(CUR_Z)) &&
                         (ef[DY_LSB +: COORD_W] == COORD_W'(CUR_Y)) &&
                         (ef[DX_LSB +: COORD_W] == COORD_W'(CUR_X));

`ifdef CHECK_PAYLOAD_EN
    logic [15:0] c_exp, c_exp_n;
`endif

    always_comb begin
      c_state_n = c_state;
      c_cnt_n   = c_cnt;
      c_rcvd_n  = c_rcvd;
      c_err_n   = c_err;
`ifdef CHECK_PAYLOAD_EN
      c_exp_n   = c_exp;
`endif
      if (eject_valid[p]) begin
        if (e_type == 2'b00 || !dest_ok) c_err_n = 1'b1;
        case (c_state)
          C_WAIT_HEAD: begin
            if (e_type == T_HEAD) begin
              c_state_n = C_IN_PKT;
              c_cnt_n   = '0;
            end else begin
              c_err_n = 1'b1;
            end
          end
          C_IN_PKT: begin
            if (e_type == T_HEAD) begin
              c_err_n = 1'b1;
              c_cnt_n = '0;
            end else if (e_type != 2'b00) begin
              c_cnt_n = cnt_inc;
              if (e_type == T_TAIL) begin
                c_state_n = C_WAIT_HEAD;
                if (cnt_inc == 16'(PKT_FLITS - 1)) begin
                  if (c_rcvd != 16'hFFFF) c_rcvd_n = c_rcvd + 16'd1;
`ifdef CHECK_PAYLOAD_EN
                  c_exp_n = c_exp + 16'd1;
`endif
                end else begin
                  c_err_n = 1'b1;
                end
              end
            end
          end
          default: c_state_n = C_WAIT_HEAD;
        endcase
`ifdef CHECK_PAYLOAD_EN
        if ((e_type == T_HEAD || e_type == T_TAIL) && ef[15:0] != c_exp) c_err_n = 1'b1;
`endif
      end
      if (run_start) begin
        c_state_n = C_WAIT_HEAD;
        c_cnt_n   = '0;
        c_rcvd_n  = '0;
        c_err_n   = 1'b0;
`ifdef CHECK_PAYLOAD_EN
        c_exp_n   = '0;
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        c_state <= C_WAIT_HEAD;
        c_cnt   <= '0;
        c_rcvd  <= '0;
        c_err   <= 1'b0;
`ifdef CHECK_PAYLOAD_EN
        c_exp   <= '0;
`endif
      end else begin
        c_state <= c_state_n;
        c_cnt   <= c_cnt_n;
        c_rcvd  <= c_rcvd_n;
        c_err   <= c_err_n;
`ifdef CHECK_PAYLOAD_EN
        c_exp   <= c_exp_n;
`endif
      end
    end

    assign rcvd_pkts[p*16 +: 16] = c_rcvd;
    assign err[p]                = c_err;
    assign port_done[p] = (g_sent == 16'(PKT_NUM)) && (c_rcvd == 16'(PKT_NUM));
  end

endmodule

// File: tb/tb_nn_traffic_unit.sv
// Scoreboard bench for nn_traffic_unit: random backpressure, loopback ejection, error injection.
module tb_nn_traffic_unit;
  localparam int CX = 3, CY = 0, CZ = 3, XS = 4, YS = 4, ZS = 4, CW = 3;
  localparam int NP = 6, FW = 64, PF = 4, PN = 8, IV = 3;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [NP*FW-1:0]  inject_flit;
  logic [NP-1:0]     inject_valid;
  logic [NP-1:0]     inject_avail;
  logic [NP*FW-1:0]  eject_flit;
  logic [NP-1:0]     eject_valid;
  logic [NP*16-1:0]  sent_pkts, rcvd_pkts;
  logic [NP-1:0]     err;
  logic              done;

  nn_traffic_unit #(
    .CUR_X(CX), .CUR_Y(CY), .CUR_Z(CZ), .XSIZE(XS), .YSIZE(YS), .ZSIZE(ZS),
    .COORD_W(CW), .NUM_PORTS(NP), .FLIT_W(FW), .PKT_FLITS(PF), .PKT_NUM(PN), .INTERVAL(IV)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .inject_flit(inject_flit), .inject_valid(inject_valid), .inject_avail(inject_avail),
    .eject_flit(eject_flit), .eject_valid(eject_valid),
    .sent_pkts(sent_pkts), .rcvd_pkts(rcvd_pkts), .err(err), .done(done)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared state ----------------
  int vectors = 0, miscompares = 0;
  int c0 = 0;
  int avail_pct = 100;
  bit loop_en = 1'b0, mon_en = 1'b0;
  logic [NP-1:0]    man_v = '0, man_avail = '0;
  logic [NP*FW-1:0] man_f = '0;
  logic [FW-1:0]    exp_q[NP][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference flit: dest is the neighbour in direction p, or this node when at_node is set.
  function automatic logic [FW-1:0] model_flit(input int p, input int k, input int i, input bit at_node);
    int dx, dy, dz;
    logic [FW-1:0] f;
    dx = CX; dy = CY; dz = CZ;
    if (!at_node) begin
      case (p)
        0: dx = (CX + 1) % XS;
        1: dy = (CY + 1) % YS;
        2: dz = (CZ + 1) % ZS;
        3: dx = (CX + XS - 1) % XS;
        4: dy = (CY + YS - 1) % YS;
        default: dz = (CZ + ZS - 1) % ZS;
      endcase
    end
    f = '0;
    f[FW-1 -: 2]        = (i == 0) ? 2'b01 : ((i == PF - 1) ? 2'b11 : 2'b10);
    f[FW-3]             = 1'b1;
    f[FW-4 -: CW]       = CW'(dz);
    f[FW-4-CW -: CW]    = CW'(dy);
    f[FW-4-2*CW -: CW]  = CW'(dx);
    f[FW-4-3*CW -: 4]   = 4'(p);
    f[15:0]             = 16'(k);
    return f;
  endfunction

  // ---------------- router model: random avail, loop accepted flits back to eject ----------------
  initial begin
    logic [NP-1:0]    fwd_v;
    logic [NP*FW-1:0] fwd_f;
    logic [FW-1:0]    tmp;
    fwd_v = '0; fwd_f = '0;
    inject_avail = '0; eject_valid = '0; eject_flit = '0;
    forever begin
      @(negedge clk);
      if (loop_en) begin
        eject_valid = fwd_v;
        eject_flit  = fwd_f;
        for (int p = 0; p < NP; p++)
          inject_avail[p] = (int'($urandom_range(0, 99)) < avail_pct);
        for (int p = 0; p < NP; p++) begin
          fwd_v[p] = inject_valid[p] && inject_avail[p];
          tmp = inject_flit[p*FW +: FW];
          tmp[FW-4 -: 3*CW] = {CW'(CZ), CW'(CY), CW'(CX)};
          fwd_f[p*FW +: FW] = tmp;
        end
      end else begin
        fwd_v = '0;
        eject_valid  = man_v;
        eject_flit   = man_f;
        inject_avail = man_avail;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [NP-1:0]    prev_v, prev_a, first_seen;
    logic [NP*FW-1:0] prev_f;
    logic [FW-1:0]    cur_f, exp_f;
    prev_v = '0; prev_a = '0; prev_f = '0; first_seen = '0;
    forever begin
      @(negedge clk); #3;
      if (!mon_en) begin
        prev_v = '0; first_seen = '0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          cur_f = inject_flit[p*FW +: FW];
          if (prev_v[p] && !prev_a[p]) begin
            check("hold_valid", 64'(inject_valid[p]), 64'd1);
            check("hold_flit", 64'(cur_f), 64'(prev_f[p*FW +: FW]));
          end
          if (inject_valid[p] && !first_seen[p]) begin
            first_seen[p] = 1'b1;
            check("first_head_cycle", 64'(cyc - c0), 64'(IV));
          end
          if (inject_valid[p] && inject_avail[p]) begin
            if (exp_q[p].size() == 0) begin
              check("extra_flit", 64'(cur_f), 64'd0);
            end else begin
              exp_f = exp_q[p].pop_front();
              check("inject_flit", 64'(cur_f), 64'(exp_f));
            end
          end
          prev_v[p] = inject_valid[p];
          prev_a[p] = inject_avail[p];
          prev_f[p*FW +: FW] = cur_f;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_run(input int pct);
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      for (int k = 0; k < PN; k++)
        for (int i = 0; i < PF; i++) exp_q[p].push_back(model_flit(p, k, i, 1'b0));
    end
    @(negedge clk); #1;
    avail_pct = pct; loop_en = 1'b1; mon_en = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; c0 = cyc;
    check("start_clears_err", 64'(err), 64'd0);
    check("start_clears_sent", 64'(sent_pkts), 64'd0);
    check("start_clears_rcvd", 64'(rcvd_pkts), 64'd0);
  endtask

  task automatic finish_run();
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    #2;
    check("done_reached", 64'(done), 64'd1);
    for (int p = 0; p < NP; p++) begin
      check("sent_pkts", 64'(sent_pkts[p*16 +: 16]), 64'(PN));
      check("rcvd_pkts", 64'(rcvd_pkts[p*16 +: 16]), 64'(PN));
      check("flits_left", 64'(exp_q[p].size()), 64'd0);
    end
    check("err_after_run", 64'(err), 64'd0);
    repeat (6) @(negedge clk); #2;
    check("idle_after_done", 64'(inject_valid), 64'd0);
  endtask

  task automatic send_eject(input int p, input logic [FW-1:0] f);
    @(negedge clk); #1;
    man_v = '0; man_v[p] = 1'b1; man_f = '0; man_f[p*FW +: FW] = f;
    @(negedge clk); #1;
    man_v = '0;
  endtask

  task automatic eject_check(input string name, input int p, input logic [FW-1:0] f, input logic exp_err);
    send_eject(p, f);
    @(negedge clk); #2;
    check(name, 64'(err[p]), 64'(exp_err));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [FW-1:0] f;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk); #2;
    check("rst_inject_valid", 64'(inject_valid), 64'd0);
    check("rst_inject_flit", 64'(inject_flit[63:0]), 64'd0);
    check("rst_sent", 64'(sent_pkts), 64'd0);
    check("rst_rcvd", 64'(rcvd_pkts), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Run 1: random backpressure, with a start pulse mid-run that must be ignored.
    begin_run(60);
    repeat (6) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    finish_run();

    // Directed ejection errors while idle.
    @(negedge clk); #1;
    mon_en = 1'b0; loop_en = 1'b0;
    eject_check("body_without_head", 0, model_flit(0, PN, 1, 1'b1), 1'b1);
    eject_check("head_ok", 1, model_flit(1, PN, 0, 1'b1), 1'b0);
    eject_check("short_tail", 1, model_flit(1, PN, PF - 1, 1'b1), 1'b1);
    eject_check("wrong_dest", 2, model_flit(2, PN, 0, 1'b0), 1'b1);
    for (int i = 0; i < PF; i++) send_eject(3, model_flit(3, PN, i, 1'b1));
    @(negedge clk); #2;
    check("good_pkt_err", 64'(err[3]), 64'd0);
    check("good_pkt_rcvd", 64'(rcvd_pkts[3*16 +: 16]), 64'(PN + 1));
    f = model_flit(4, PN, 0, 1'b1); f[FW-1 -: 2] = 2'b00;
    eject_check("type_00", 4, f, 1'b1);
    send_eject(5, model_flit(5, PN, 0, 1'b1));
    eject_check("head_in_pkt", 5, model_flit(5, PN, 0, 1'b1), 1'b1);
    repeat (5) @(negedge clk); #2;
    check("err_sticky", 64'(err), 64'h37);

    // Run 2: reset in mid-packet aborts everything.
    begin_run(100);
    repeat (IV + 2) @(negedge clk); #1;
    check("midpkt_valid", 64'(inject_valid), 64'h3F);
    mon_en = 1'b0; loop_en = 1'b0; rst = 1'b1;
    @(negedge clk); #2;
    check("abort_valid", 64'(inject_valid), 64'd0);
    check("abort_flit", 64'(inject_flit[FW-1:0]), 64'd0);
    check("abort_sent", 64'(sent_pkts), 64'd0);
    check("abort_rcvd", 64'(rcvd_pkts), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    rst = 1'b0;

    // Run 3: restart from reset; sequence numbers start again at 0.
    begin_run(45);
    finish_run();

    // A structurally good packet carrying a skipped sequence number.
    @(negedge clk); #1;
    mon_en = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < PF; i++) send_eject(0, model_flit(0, PN + 1, i, 1'b1));
    @(negedge clk); #2;
`ifdef CHECK_PAYLOAD_EN
    check("skipped_seq", 64'(err[0]), 64'd1);
`else
    check("skipped_seq_ignored", 64'(err[0]), 64'd0);
`endif
    check("skipped_seq_rcvd", 64'(rcvd_pkts[15:0]), 64'(PN + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected finish before it", cyc);
    $fatal(1, "timeout");
  end
endmodule
